// File: rtl/clk_div_pkg.sv
// Shared types and default sizing for the clock divider and its reconfiguration controller.
package clk_div_pkg;

  localparam int CLK_DIV_WIDTH   = 16;
  localparam int CLK_DIV_DEF_DIV = 10;
  localparam int CLK_DIV_MIN_DIV = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    GATE  = 2'd2,
    LOAD  = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/clk_div_ctrl_sync2.sv
// Two-flop synchronizer bringing the divider feedback clock into the clkin domain.
module sync2 (
  input  logic clkin,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Round-robin reconfiguration controller: gates the divider while its output is low,
// loads a new divisor, then re-enables it so clkout never produces a runt pulse.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int WIDTH   = CLK_DIV_WIDTH,
  parameter int DEF_DIV = CLK_DIV_DEF_DIV,
  parameter int MIN_DIV = CLK_DIV_MIN_DIV,
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic               clkin,
  input  logic               reset,
  input  logic               run,
  input  logic [1:0]         req_valid,
  input  logic [2*WIDTH-1:0] req_div,
  output logic [1:0]         req_ready,
  input  logic               div_clk,
  output logic               div_en,
  output logic [WIDTH-1:0]   div_divisor,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int CNT_W = (TO_W > 8) ? TO_W : 8;

  ctrl_state_t      state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             rr, rr_n;
  logic [WIDTH-1:0] pend, pend_n;
  logic             en_n;
  logic [WIDTH-1:0] divisor_n;
  logic             done_n, err_n;
  logic             fb_sync;
  logic             grant;
  logic             gnt_idx;
  logic [WIDTH-1:0] sel_div;

  sync2 u_fb_sync (
    .clkin (clkin),
    .reset (reset),
    .d     (div_clk),
    .q     (fb_sync)
  );

  // With both requesters waiting the pointer decides; otherwise the lone requester wins.
  always_comb begin
    gnt_idx = (req_valid[0] && req_valid[1]) ? rr : req_valid[1];
    sel_div = gnt_idx ? req_div[2*WIDTH-1:WIDTH] : req_div[WIDTH-1:0];
    grant   = (state == IDLE) && (|req_valid);
    req_ready = 2'b00;
    if (grant) begin
      req_ready = gnt_idx ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    rr_n      = rr;
    pend_n    = pend;
    en_n      = div_en;
    divisor_n = div_divisor;
    done_n    = 1'b0;
    err_n     = 1'b0;
    unique case (state)
      IDLE: begin
        en_n = run;
        if (grant) begin
          rr_n = ~gnt_idx;
          if (sel_div < WIDTH'(MIN_DIV)) begin
            err_n = 1'b1;
          end else begin
            pend_n  = sel_div;
            en_n    = 1'b0;
            cnt_n   = '0;
            state_n = DRAIN;
          end
        end
      end
      // A stuck-high feedback clock must not hang the controller, hence the timeout.
      DRAIN: begin
        en_n = 1'b0;
        if (!fb_sync || (cnt == CNT_W'(TIMEOUT))) begin
          cnt_n   = '0;
          state_n = GATE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      GATE: begin
        en_n = 1'b0;
        if (cnt == CNT_W'(SETTLE - 1)) begin
          cnt_n   = '0;
          state_n = LOAD;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      LOAD: begin
        divisor_n = pend;
        en_n      = run;
        done_n    = 1'b1;
        state_n   = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      rr          <= 1'b0;
      pend        <= WIDTH'(DEF_DIV);
      div_en      <= 1'b0;
      div_divisor <= WIDTH'(DEF_DIV);
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      rr          <= rr_n;
      pend        <= pend_n;
      div_en      <= en_n;
      div_divisor <= divisor_n;
      busy        <= (state_n != IDLE);
      done        <= done_n;
      err         <= err_n;
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: reset, single/round-robin grants, rejects, drain timing,
// timeout (second instance with TIMEOUT=20) and a behavioural divider for runt checking.
module tb_clk_div_ctrl;
  import clk_div_pkg::*;

  logic        clkin = 1'b0;
  logic        reset;
  logic        run;
  logic [1:0]  req_valid;
  logic [31:0] req_div;
  logic        fb_manual;
  logic        live;
  logic        mclk;
  logic        div_clk_w;

  logic [1:0]  req_ready, to_ready;
  logic        div_en, to_en;
  logic [15:0] div_divisor, to_divisor;
  logic        busy, to_busy, done, to_done, err, to_err;

  int n_asserts = 0;
  int n_fail    = 0;
  int done_cnt  = 0;
  int done_snap;
  logic both_hi = 1'b0;

  int   mcnt;
  int   ph_len;
  int   last_len = 0;
  int   runt_cnt = 0;
  logic ph_first;
  logic ph_last_clk;

  always #5 clkin = ~clkin;

  assign div_clk_w = live ? mclk : fb_manual;

  clk_div_ctrl dut (
    .clkin       (clkin),
    .reset       (reset),
    .run         (run),
    .req_valid   (req_valid),
    .req_div     (req_div),
    .req_ready   (req_ready),
    .div_clk     (div_clk_w),
    .div_en      (div_en),
    .div_divisor (div_divisor),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  clk_div_ctrl #(.TIMEOUT(20)) dut_to (
    .clkin       (clkin),
    .reset       (reset),
    .run         (run),
    .req_valid   (req_valid),
    .req_div     (req_div),
    .req_ready   (to_ready),
    .div_clk     (div_clk_w),
    .div_en      (to_en),
    .div_divisor (to_divisor),
    .busy        (to_busy),
    .done        (to_done),
    .err         (to_err)
  );

  // Behavioural divider: counter freezes while disabled, high for the first divisor/2 counts.
  always @(posedge clkin or posedge reset) begin
    if (reset) begin
      mcnt <= 0;
      mclk <= 1'b0;
    end else if (div_en) begin
      if (mcnt >= int'(div_divisor) - 1) begin
        mcnt <= 0;
        mclk <= (0 < int'(div_divisor) / 2);
      end else begin
        mcnt <= mcnt + 1;
        mclk <= ((mcnt + 1) < int'(div_divisor) / 2);
      end
    end
  end

  // Phase-length tracker for the live divider; the partial first phase is ignored.
  always @(negedge clkin) begin
    if (!live) begin
      ph_len      <= 0;
      ph_first    <= 1'b1;
      ph_last_clk <= mclk;
    end else if (mclk == ph_last_clk) begin
      ph_len <= ph_len + 1;
    end else begin
      if (!ph_first && ph_len < 2) runt_cnt <= runt_cnt + 1;
      last_len    <= ph_len;
      ph_first    <= 1'b0;
      ph_len      <= 1;
      ph_last_clk <= mclk;
    end
  end

  always @(posedge clkin) begin
    if (done) done_cnt <= done_cnt + 1;
    if (req_ready == 2'b11) both_hi <= 1'b1;
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clkin);
  endtask

  task automatic applyStimulus(input logic [1:0] v, input logic [15:0] d0, input logic [15:0] d1);
    req_valid = v;
    req_div   = {d1, d0};
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_asserts++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  initial begin
    reset     = 1'b1;
    run       = 1'b1;
    live      = 1'b0;
    fb_manual = 1'b0;
    applyStimulus(2'b00, 16'd0, 16'd0);

    // Reset state
    step(2);
    checkOutput("rst_div_en", div_en, 0);
    checkOutput("rst_divisor", div_divisor, 10);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    reset = 1'b0;
    step();
    checkOutput("rel_div_en", div_en, 1);

    // Single request, feedback low
    $display("[TB] single request");
    applyStimulus(2'b01, 16'd6, 16'd0);
    #1 checkOutput("single_ready", req_ready, 2'b01);
    step();
    checkOutput("single_ready_drop", req_ready, 2'b00);
    applyStimulus(2'b00, 16'd0, 16'd0);
    checkOutput("single_busy", busy, 1);
    for (int j = 0; j < 6; j++) begin
      if (j > 0) step();
      checkOutput("single_en_low", div_en, 0);
      checkOutput("single_no_done", done, 0);
    end
    checkOutput("single_div_hold", div_divisor, 10);
    step();
    checkOutput("single_done", done, 1);
    checkOutput("single_divisor", div_divisor, 6);
    checkOutput("single_en_back", div_en, 1);
    checkOutput("single_idle", busy, 0);
    step();
    checkOutput("single_done_pulse", done, 0);

    // Reset in the middle of GATE
    $display("[TB] reset mid-gate");
    applyStimulus(2'b01, 16'd5, 16'd0);
    step();
    applyStimulus(2'b00, 16'd0, 16'd0);
    step(2);
    checkOutput("mg_in_gate", dut.state, GATE);
    reset = 1'b1;
    #1;
    checkOutput("mg_async_en", div_en, 0);
    checkOutput("mg_async_div", div_divisor, 10);
    checkOutput("mg_async_busy", busy, 0);
    checkOutput("mg_async_state", dut.state, IDLE);
    step();
    reset = 1'b0;
    step();
    checkOutput("mg_rel_en", div_en, 1);
    checkOutput("mg_rel_busy", busy, 0);
    checkOutput("mg_rel_div", div_divisor, 10);

    // Round-robin with both requesters active
    $display("[TB] round robin");
    done_snap = done_cnt;
    applyStimulus(2'b11, 16'd8, 16'd12);
    #1 checkOutput("rr_first", req_ready, 2'b01);
    step();
    applyStimulus(2'b10, 16'd8, 16'd12);
    #1 checkOutput("rr_wait", req_ready, 2'b00);
    step(5);
    checkOutput("rr_done1", done, 0);
    step();
    checkOutput("rr_done1", done, 1);
    checkOutput("rr_div1", div_divisor, 8);
    checkOutput("rr_second", req_ready, 2'b10);
    step();
    applyStimulus(2'b00, 16'd0, 16'd0);
    step(6);
    checkOutput("rr_done2", done, 1);
    checkOutput("rr_div2", div_divisor, 12);
    step(2);
    checkOutput("rr_done_count", done_cnt - done_snap, 2);
    checkOutput("rr_never_both", both_hi, 0);

    // Rejected divisors
    $display("[TB] reject");
    applyStimulus(2'b10, 16'd0, 16'd1);
    #1 checkOutput("rej_ready", req_ready, 2'b10);
    step();
    applyStimulus(2'b00, 16'd0, 16'd0);
    checkOutput("rej_err", err, 1);
    checkOutput("rej_div", div_divisor, 12);
    checkOutput("rej_en", div_en, 1);
    checkOutput("rej_busy", busy, 0);
    checkOutput("rej_rr", dut.rr, 0);
    step();
    checkOutput("rej_err_pulse", err, 0);
    checkOutput("rej_en2", div_en, 1);
    applyStimulus(2'b01, 16'd0, 16'd0);
    #1 checkOutput("rej0_ready", req_ready, 2'b01);
    step();
    applyStimulus(2'b00, 16'd0, 16'd0);
    checkOutput("rej0_err", err, 1);
    checkOutput("rej0_rr", dut.rr, 1);
    checkOutput("rej0_en", div_en, 1);

    // Drain wait on feedback, plus timeout on the second instance
    $display("[TB] drain and timeout");
    fb_manual = 1'b1;
    step(4);
    applyStimulus(2'b01, 16'd7, 16'd0);
    #1 checkOutput("dr_ready", req_ready, 2'b01);
    step();
    applyStimulus(2'b00, 16'd0, 16'd0);
    checkOutput("dr_state0", dut.state, DRAIN);
    for (int j = 1; j <= 57; j++) begin
      step();
      if (j == 20) checkOutput("to_still_drain", dut_to.state, DRAIN);
      if (j == 21) begin
        checkOutput("to_gate", dut_to.state, GATE);
        checkOutput("dr_hold", dut.state, DRAIN);
      end
      if (j == 26) begin
        checkOutput("to_done", to_done, 1);
        checkOutput("to_div", to_divisor, 7);
      end
      if (j == 49) begin
        checkOutput("dr_before_fall", dut.state, DRAIN);
        fb_manual = 1'b0;
      end
      if (j == 51) checkOutput("dr_sync_delay", dut.state, DRAIN);
      if (j == 52) checkOutput("dr_left", dut.state, GATE);
      if (j == 56) checkOutput("dr_en_low", div_en, 0);
      if (j == 57) begin
        checkOutput("dr_done", done, 1);
        checkOutput("dr_div", div_divisor, 7);
        checkOutput("dr_en_back", div_en, 1);
      end
    end

    // Live divider: switch 10 -> 4 while the feedback clock toggles
    $display("[TB] live divider");
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    live = 1'b1;
    step(40);
    applyStimulus(2'b01, 16'd4, 16'd0);
    #1 checkOutput("live_ready", req_ready, 2'b01);
    step();
    applyStimulus(2'b00, 16'd0, 16'd0);
    step(60);
    checkOutput("live_div", div_divisor, 4);
    checkOutput("live_busy", busy, 0);
    checkOutput("live_no_runt", runt_cnt, 0);
    checkOutput("live_phase", last_len, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Reconfiguration controller and arbiter for the clock divider. Two requesters each ask for a new divisor over a valid/ready handshake. The controller grants one at a time in round-robin order, gates the divider off at a safe point (feedback clock low), loads the new divisor, and re-enables it. This keeps `clkout` free of runt pulses during a change. It sits between software/config logic and the divider's `en`/`divisor` inputs.

## Interface
- `WIDTH`, 16: divisor width; matches the divider's `divisor` port.
- `DEF_DIV`, 10: divisor driven from reset until the first accepted request.
- `MIN_DIV`, 2: smallest legal divisor; smaller requests are rejected.
- `SETTLE`, 4: cycles `div_en` is held low after the drain point before the load (1..255).
- `TIMEOUT`, 1023: maximum cycles spent in DRAIN waiting for the feedback clock to go low.
- `clkin  in  1`: system clock; all logic on the rising edge.
- `reset  in  1`: asynchronous, active-high reset.
- `run  in  1`: host enable; sets `div_en` whenever the controller is idle.
- `req_valid  in  2`: per-requester request valid.
- `req_div  in  2*WIDTH`: requester i divisor in bits [i*WIDTH +: WIDTH].
- `req_ready  out  1 per requester (2)`: one-cycle grant; the transfer occurs when valid and ready are both high.
- `div_clk  in  1`: divider `clkout` fed back; asynchronous to the state logic, 2-flop synchronized internally.
- `div_en  out  1`: drives the divider `en`.
- `div_divisor  out  WIDTH`: drives the divider `divisor`.
- `busy  out  1`: high in any state other than IDLE.
- `done  out  1`: one-cycle pulse when a reprogram completes.
- `err  out  1`: one-cycle pulse when a request is rejected (divisor < `MIN_DIV`).

## Operation
- States: IDLE, DRAIN, GATE, LOAD.
- IDLE:
  - `div_en` = `run`.
  - If any `req_valid` is high, grant one requester per round-robin and raise its `req_ready` for that cycle. Only one `req_ready` bit is ever high.
  - Capture the requester's `req_div` into the pending register.
- Round-robin:
  - Pointer `rr` resets to 0; requester `rr` has priority.
  - After any grant, `rr` = the other requester.
  - A single active requester is granted regardless of `rr`.
- On grant with divisor < `MIN_DIV`: `err` pulses next cycle; state stays IDLE; `div_en`/`div_divisor` are unchanged; `rr` still advances.
- On grant with a legal divisor: go to DRAIN; `div_en` = 0 from the next cycle.
- DRAIN:
  - Wait for the synchronized `div_clk` = 0, or `TIMEOUT` cycles elapsed.
  - Either condition moves to GATE and clears the counter.
- GATE: hold `div_en` = 0 for exactly `SETTLE` cycles, then go to LOAD.
- LOAD (one cycle): `div_divisor` <= pending; next state IDLE.
- Entering IDLE from LOAD: `done` pulses and `div_en` <= `run`, both in the same cycle.
- Requests arriving while busy wait; `req_ready` is held low until IDLE. Requesters must hold `req_valid`/`req_div` stable until they are granted.
- Changing `run` while busy has no effect until IDLE.
- Reset mid-operation aborts the sequence. All state returns to reset values; the pending request is lost.

## Timing
- Reset values:
  - state IDLE, `rr` = 0.
  - `div_en` = 0, `div_divisor` = `DEF_DIV`.
  - `req_ready` = 0, `busy` = 0, `done` = 0, `err` = 0.
  - sync flops = 0.
- Outputs are registered, except `req_ready`, which is combinational from state IDLE and `req_valid` and is therefore valid in the same cycle.
- Latency from the grant edge E0:
  - `div_en` low at E0+1.
  - Minimum to `done` = `SETTLE`+2 cycles (DRAIN 1 cycle, GATE `SETTLE` cycles, LOAD 1 cycle, with feedback already low).
  - Maximum to `done` = `TIMEOUT`+`SETTLE`+2 cycles.
- Feedback synchronizer adds 2 cycles of delay; DRAIN samples only the synchronized value.
- Back-to-back: the earliest next grant is in the `done` cycle. IDLE accepts on the same cycle that `done` pulses.
- `div_divisor` changes only in LOAD, and only while `div_en` = 0.

## Structure
- Shared package `clk_div_pkg`:
  - state enum (IDLE/DRAIN/GATE/LOAD).
  - default `WIDTH`, `DEF_DIV`, `MIN_DIV` constants, reused by the divider top.
- Sub-module `sync2`: 2-flop synchronizer with asynchronous reset, used for `div_clk`.
- Arbiter logic stays inline; no separate module.

## Test plan
- Reset: assert `reset` mid-GATE. Require:
  - `div_en` = 0 and `div_divisor` = 10 immediately (asynchronous).
  - after release, IDLE, `busy` = 0, and `div_en` follows `run` = 1 at the next edge.
- Single request: requester 0 requests 6 with `div_clk` held low, `SETTLE` = 4. Require:
  - `req_ready[0]` for 1 cycle.
  - `div_en` low for 6 cycles.
  - `div_divisor` = 6 and `done` at grant+6.
- Round-robin: both requesters valid (0 → 8, 1 → 12) from reset. Require:
  - grant order 0 then 1.
  - final `div_divisor` = 12, two `done` pulses, never both `req_ready` bits high.
- Reject: requester 1 requests 1. Require:
  - `req_ready[1]` high, then `err` pulses once.
  - `div_divisor` unchanged, `div_en` never drops, `rr` = 0 afterwards.
- Drain: hold `div_clk` high for 50 cycles after the grant, then low. Require:
  - DRAIN is left 2–3 cycles after `div_clk` falls (synchronizer delay).
  - with `TIMEOUT` = 20 and `div_clk` stuck high, GATE is entered at E0+21.
- Live divider: connect the real divider and switch 10 → 4 while `clkout` toggles. Check that no `clkout` high or low phase is shorter than min(old, new)/2 input cycles.
